// File: rtl/chan_pkg.sv
// chan_pkg: shared constants and saturation helper for channel-model blocks
package chan_pkg;
  localparam int NOISE_W = 24;
  localparam int NOISE_FIELD_W = 6;
  localparam int NOISE_FIELDS = 4;
  localparam int NOISE_OFFSET = 126;
  localparam int SHIFT_W = 4;
  // clamps a 25-bit signed value to the signed range of a w-bit word; result stays 25 bits wide
  function automatic logic signed [24:0] saturate(input logic signed [24:0] s, input int w);
    logic signed [24:0] hi;
    logic signed [24:0] lo;
    hi = 25'((32'sd1 <<< (w - 1)) - 32'sd1);
    lo = ~hi;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/noise_shaper.sv
// noise_shaper: sums four 6-bit fields of a noise word into a zero-mean 9-bit value
// ports: noise_q (24-bit generator word), bypass (forces 0), c (signed -126..+126)
module noise_shaper
  import chan_pkg::*;
(
  input  logic [NOISE_W-1:0] noise_q,
  input  logic               bypass,
  output logic signed [8:0]  c
);
  logic [7:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NOISE_FIELDS; i++) sum = sum + 8'(noise_q[i*NOISE_FIELD_W +: NOISE_FIELD_W]);
  end
  assign c = bypass ? '0 : $signed({1'b0, sum}) - 9'(NOISE_OFFSET);
endmodule

// File: rtl/channel_noise_adder.sv
// channel_noise_adder: adds shaped, shifted noise to a sample stream with saturation
// ports: clk, reset (async active-low), in_* (valid/ready input stream), noise_q/noise_en
// (generator word and step enable), noise_shift, bypass, out_* (valid/ready output stream),
// clear_count, sat_count (sticky count of clamped outputs)
module channel_noise_adder
  import chan_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NOISE_W-1:0]       noise_q,
  output logic                     noise_en,
  input  logic [SHIFT_W-1:0]       noise_shift,
  input  logic                     bypass,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     clear_count,
  output logic [CNT_W-1:0]         sat_count
);
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_data;
  logic signed [8:0]        s1_c;
  logic [SHIFT_W-1:0]       s1_shift;
  logic signed [8:0]        c;
  logic signed [24:0]       n;
  logic signed [24:0]       s;
  logic signed [24:0]       s_sat;
  logic                     sat;
  logic                     adv1;
  logic                     adv2;
  noise_shaper u_shaper (.noise_q(noise_q), .bypass(bypass), .c(c));
  assign adv2 = !out_valid || out_ready;
  assign adv1 = !s1_valid || adv2;
  // gated so the generator never steps while reset is held
  assign in_ready = reset && adv1;
  assign noise_en = in_valid && in_ready;
  assign n = {{16{s1_c[8]}}, s1_c} <<< s1_shift;
  assign s = {{(25-DATA_W){s1_data[DATA_W-1]}}, s1_data} + n;
  assign s_sat = saturate(s, DATA_W);
  assign sat = s_sat != s;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_c <= '0;
      s1_shift <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      sat_count <= '0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (noise_en) begin
        s1_data <= in_data;
        s1_c <= c;
        s1_shift <= noise_shift;
      end
      if (adv2) out_valid <= s1_valid;
      if (adv2 && s1_valid) out_data <= s_sat[DATA_W-1:0];
      if (clear_count) sat_count <= '0;
      else if (adv2 && s1_valid && sat && sat_count != '1) sat_count <= sat_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_channel_noise_adder.sv
// tb_channel_noise_adder: directed self-checking bench for channel_noise_adder
module tb_channel_noise_adder;
  logic               clk;
  logic               reset;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [23:0]        noise_q;
  logic               noise_en;
  logic [3:0]         noise_shift;
  logic               bypass;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               clear_count;
  logic [15:0]        sat_count;
  int checks = 0;
  int errors = 0;
  channel_noise_adder #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .noise_q(noise_q), .noise_en(noise_en), .noise_shift(noise_shift), .bypass(bypass),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clear_count(clear_count), .sat_count(sat_count)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int d, input logic [23:0] q, input logic [3:0] sh, input logic byp);
    in_valid = 1;
    in_data = 16'(d);
    noise_q = q;
    noise_shift = sh;
    bypass = byp;
    #1;
  endtask
  initial begin
    reset = 0;
    in_valid = 1;
    in_data = 0;
    noise_q = 0;
    noise_shift = 0;
    bypass = 0;
    out_ready = 1;
    clear_count = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_noise_en", noise_en, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_out_data", out_data, 0);
    #10;
    in_valid = 0;
    reset = 1;
    step();
    // offset: all-zero noise gives c = -126
    drive(1000, 24'h000000, 0, 0);
    chk("t1_noise_en_acc", noise_en, 1);
    step();
    in_valid = 0;
    #1;
    chk("t1_noise_en_idle", noise_en, 0);
    chk("t1_out_valid_early", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 874);
    chk("t1_sat_count", sat_count, 0);
    // saturation high, then clear colliding with another saturation
    drive(32700, 24'hFFFFFF, 0, 0);
    step();
    in_valid = 0;
    step();
    chk("t2_out_data", out_data, 32767);
    chk("t2_sat_count", sat_count, 1);
    drive(32700, 24'hFFFFFF, 0, 0);
    step();
    in_valid = 0;
    clear_count = 1;
    step();
    clear_count = 0;
    chk("t2_out_data2", out_data, 32767);
    chk("t2_clear_prio", sat_count, 0);
    // field extraction and shift
    drive(0, 24'h041041, 4, 0);
    step();
    in_valid = 0;
    step();
    chk("t3_shift4", out_data, -1952);
    chk("t3_sat_none", sat_count, 0);
    drive(0, 24'h000000, 15, 0);
    step();
    in_valid = 0;
    step();
    chk("t3_shift15", out_data, -32768);
    chk("t3_sat_low", sat_count, 1);
    // bypass streaming back to back
    drive(5, 24'h3A5C71, 7, 1);
    chk("t4_en0", noise_en, 1);
    step();
    drive(-7, 24'hC0FFEE, 9, 1);
    chk("t4_en1", noise_en, 1);
    step();
    chk("t4_out0", out_data, 5);
    drive(32767, 24'h123456, 15, 1);
    chk("t4_en2", noise_en, 1);
    step();
    in_valid = 0;
    chk("t4_out1", out_data, -7);
    step();
    chk("t4_out2", out_data, 32767);
    chk("t4_valid2", out_valid, 1);
    step();
    chk("t4_drained", out_valid, 0);
    chk("t4_sat_hold", sat_count, 1);
    // backpressure: only two samples fit while the output is stalled
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      drive(100 + 10 * i, 24'h000000, 0, 1);
      chk($sformatf("t5_en%0d", i), noise_en, i < 2 ? 1 : 0);
      chk($sformatf("t5_rdy%0d", i), in_ready, i < 2 ? 1 : 0);
      if (i >= 2) chk($sformatf("t5_hold%0d", i), out_data, 100);
      step();
    end
    in_valid = 0;
    out_ready = 1;
    #1;
    chk("t5_rel_valid", out_valid, 1);
    chk("t5_rel0", out_data, 100);
    step();
    chk("t5_rel1", out_data, 110);
    chk("t5_rel1_valid", out_valid, 1);
    step();
    chk("t5_drained", out_valid, 0);
    // async reset with two samples in flight
    drive(1, 24'h000000, 0, 1);
    step();
    drive(2, 24'h000000, 0, 1);
    step();
    chk("t6_inflight", out_valid, 1);
    reset = 0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_en", noise_en, 0);
    chk("t6_rst_sat", sat_count, 0);
    in_valid = 0;
    #1;
    reset = 1;
    step();
    chk("t6_no_stale0", out_valid, 0);
    step();
    chk("t6_no_stale1", out_valid, 0);
    drive(42, 24'h000000, 0, 1);
    step();
    in_valid = 0;
    chk("t6_lat1", out_valid, 0);
    step();
    chk("t6_lat2", out_valid, 1);
    chk("t6_data", out_data, 42);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
